// File: rtl/nodf_module_status_tracker.sv
// Handshake status tracker for one ap_ctrl_hs block: counts
// transactions, busy/stall cycles and per-transaction latency.
module nodf_module_status_tracker #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] ready_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] active_cycles,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] min_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic             finished,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] lat_cnt, lat_cnt_n;
  logic [CNT_W-1:0] start_n, ready_n, done_n;
  logic [CNT_W-1:0] act_n, stall_n;
  logic [CNT_W-1:0] last_n, min_n, max_n;
  logic [CNT_W-1:0] lat_v;
  logic             fin_n, perr_n, done_ev;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == ONES) ? v : v + ONE;
  endfunction

  always_comb begin
    state_n   = state;
    lat_cnt_n = lat_cnt;
    start_n   = start_cnt;
    ready_n   = ready_cnt;
    done_n    = done_cnt;
    act_n     = active_cycles;
    stall_n   = stall_cycles;
    last_n    = last_latency;
    min_n     = min_latency;
    max_n     = max_latency;
    fin_n     = finished;
    perr_n    = proto_err;
    lat_v     = '0;
    done_ev   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ap_start) begin
          start_n   = sat_inc(start_cnt);
          lat_cnt_n = ONE;
          if (ap_done) begin
            done_ev = 1'b1;
            lat_v   = ONE;
          end else begin
            state_n = RUN;
          end
        end else if (ap_done) begin
          perr_n = 1'b1;
        end
      end
      RUN: begin
        act_n     = sat_inc(active_cycles);
        lat_v     = sat_inc(lat_cnt);
        lat_cnt_n = lat_v;
        done_ev   = ap_done;
      end
      STALL: begin
        if (ap_continue) state_n = IDLE;
        else stall_n = sat_inc(stall_cycles);
      end
      FIN: ;
      default: ;
    endcase
    if (done_ev) begin
      done_n  = sat_inc(done_cnt);
      last_n  = lat_v;
      if (lat_v < min_latency) min_n = lat_v;
      if (lat_v > max_latency) max_n = lat_v;
      state_n = ap_continue ? IDLE : STALL;
    end
    if (state != FIN && ap_ready)
      ready_n = sat_inc(ready_cnt);
    // finish wins the next state but the cycle's events still count
    if (state != FIN && finish) begin
      state_n = FIN;
      fin_n   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      start_cnt     <= '0;
      ready_cnt     <= '0;
      done_cnt      <= '0;
      active_cycles <= '0;
      stall_cycles  <= '0;
      last_latency  <= '0;
      min_latency   <= ONES;
      max_latency   <= '0;
      finished      <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      state         <= state_n;
      lat_cnt       <= lat_cnt_n;
      start_cnt     <= start_n;
      ready_cnt     <= ready_n;
      done_cnt      <= done_n;
      active_cycles <= act_n;
      stall_cycles  <= stall_n;
      last_latency  <= last_n;
      min_latency   <= min_n;
      max_latency   <= max_n;
      finished      <= fin_n;
      proto_err     <= perr_n;
    end
  end

  assign status = state;

endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Directed bench for nodf_module_status_tracker, run with a
// narrow counter width so saturation is reachable.
module tb_nodf_module_status_tracker;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ap_start = 1'b0;
  logic         ap_ready = 1'b0;
  logic         ap_done = 1'b0;
  logic         ap_continue = 1'b1;
  logic         finish = 1'b0;
  logic [1:0]   status;
  logic [W-1:0] start_cnt, ready_cnt, done_cnt;
  logic [W-1:0] active_cycles, stall_cycles;
  logic [W-1:0] last_latency, min_latency, max_latency;
  logic         finished, proto_err;

  int checks = 0;
  int errors = 0;

  nodf_module_status_tracker #(.CNT_W(W)) dut (
    .clock(clock),
    .reset(reset),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_done(ap_done),
    .ap_continue(ap_continue),
    .finish(finish),
    .status(status),
    .start_cnt(start_cnt),
    .ready_cnt(ready_cnt),
    .done_cnt(done_cnt),
    .active_cycles(active_cycles),
    .stall_cycles(stall_cycles),
    .last_latency(last_latency),
    .min_latency(min_latency),
    .max_latency(max_latency),
    .finished(finished),
    .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic r,
                     input logic d, input logic c,
                     input logic f);
    ap_start    = s;
    ap_ready    = r;
    ap_done     = d;
    ap_continue = c;
    finish      = f;
    @(posedge clock);
    #1;
    ap_start = 1'b0;
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    ap_continue = 1'b1;
    finish   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 0, 1, 0);
    reset = 1'b0;
  endtask

  task automatic txn(input int lat);
    if (lat == 1) begin
      cyc(1, 0, 1, 1, 0);
    end else begin
      cyc(1, 0, 0, 1, 0);
      repeat (lat - 2) cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 1, 1, 0);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_status"}, 32'(status), 0);
    chk({p, "_start"}, 32'(start_cnt), 0);
    chk({p, "_ready"}, 32'(ready_cnt), 0);
    chk({p, "_done"}, 32'(done_cnt), 0);
    chk({p, "_active"}, 32'(active_cycles), 0);
    chk({p, "_stall"}, 32'(stall_cycles), 0);
    chk({p, "_last"}, 32'(last_latency), 0);
    chk({p, "_min"}, 32'(min_latency), 32'hF);
    chk({p, "_max"}, 32'(max_latency), 0);
    chk({p, "_finished"}, 32'(finished), 0);
    chk({p, "_perr"}, 32'(proto_err), 0);
  endtask

  initial begin
    do_reset();
    chk_reset("rst");

    // basic transaction: start, done 5 cycles later
    cyc(1, 0, 0, 1, 0);
    chk("t1_run", 32'(status), 1);
    repeat (4) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    chk("t1_start", 32'(start_cnt), 1);
    chk("t1_done", 32'(done_cnt), 1);
    chk("t1_last", 32'(last_latency), 6);
    chk("t1_min", 32'(min_latency), 6);
    chk("t1_max", 32'(max_latency), 6);
    chk("t1_active", 32'(active_cycles), 5);
    chk("t1_status", 32'(status), 0);

    // back-to-back start+done in same cycle
    do_reset();
    repeat (3) cyc(1, 0, 1, 1, 0);
    chk("t2_last", 32'(last_latency), 1);
    chk("t2_active", 32'(active_cycles), 0);
    chk("t2_done", 32'(done_cnt), 3);
    chk("t2_start", 32'(start_cnt), 3);
    chk("t2_status", 32'(status), 0);

    // stall: done with continue low, held 4 cycles
    do_reset();
    cyc(1, 0, 1, 0, 0);
    chk("t3_stall0", 32'(status), 2);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t3_stalln", 32'(status), 2);
    end
    chk("t3_cnt_hold", 32'(stall_cycles), 4);
    cyc(0, 0, 0, 1, 0);
    chk("t3_idle", 32'(status), 0);
    chk("t3_cnt", 32'(stall_cycles), 4);

    // latency statistics 3, 9, 5
    do_reset();
    txn(3);
    txn(9);
    txn(5);
    chk("t4_min", 32'(min_latency), 3);
    chk("t4_max", 32'(max_latency), 9);
    chk("t4_last", 32'(last_latency), 5);
    chk("t4_done", 32'(done_cnt), 3);
    chk("t4_active", 32'(active_cycles), 14);

    // latency 20 saturates a 4-bit counter
    txn(20);
    chk("sat_last", 32'(last_latency), 15);
    chk("sat_max", 32'(max_latency), 15);
    chk("sat_min", 32'(min_latency), 3);
    chk("sat_active", 32'(active_cycles), 15);

    // inlined callee: ready pulses with start tied low
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
    end
    chk("t5_ready", 32'(ready_cnt), 7);
    chk("t5_start", 32'(start_cnt), 0);
    chk("t5_perr0", 32'(proto_err), 0);
    cyc(0, 0, 1, 1, 0);
    chk("t5_perr", 32'(proto_err), 1);
    chk("t5_done", 32'(done_cnt), 0);
    chk("t5_status", 32'(status), 0);

    // finish mid-RUN, then frozen
    cyc(1, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    chk("t6_ready_a", 32'(ready_cnt), 8);
    chk("t6_active_a", 32'(active_cycles), 1);
    cyc(0, 1, 0, 1, 1);
    chk("t6_status", 32'(status), 3);
    chk("t6_finished", 32'(finished), 1);
    chk("t6_ready_b", 32'(ready_cnt), 9);
    chk("t6_active_b", 32'(active_cycles), 2);
    cyc(0, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 1);
    chk("t6_frz_status", 32'(status), 3);
    chk("t6_frz_ready", 32'(ready_cnt), 9);
    chk("t6_frz_active", 32'(active_cycles), 2);
    chk("t6_frz_done", 32'(done_cnt), 0);
    chk("t6_frz_start", 32'(start_cnt), 1);
    chk("t6_frz_last", 32'(last_latency), 0);
    chk("t6_frz_perr", 32'(proto_err), 1);

    // reset out of FINISHED
    do_reset();
    chk_reset("rst2");

    // reset mid-transaction discards it
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    do_reset();
    chk("t7_status", 32'(status), 0);
    cyc(0, 0, 1, 1, 0);
    chk("t7_perr", 32'(proto_err), 1);
    chk("t7_done", 32'(done_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
